// File: rtl/spi_xfer_sequencer_if.sv
// rtl/spi_xfer_sequencer_if.sv - command, response and Wishbone master signal bundle for spi_xfer_sequencer
interface spi_xfer_sequencer_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [31:0]       cmd_tx;
    logic [6:0]        cmd_len;
    logic [15:0]       cmd_div;
    logic [7:0]        cmd_ss;
    logic [2:0]        cmd_flags;
    // response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rx;
    logic              rsp_err;
    // Wishbone master port
    logic [AWIDTH-1:0] wb_adr;
    logic [DWIDTH-1:0] wb_dat_o;
    logic [DWIDTH-1:0] wb_dat_i;
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [3:0]        wb_sel;
    logic              wb_ack;
    logic              wb_err;
    logic              wb_rty;

    modport master (
        input  cmd_valid, cmd_tx, cmd_len, cmd_div, cmd_ss, cmd_flags,
        output cmd_ready,
        output rsp_valid, rsp_rx, rsp_err,
        input  rsp_ready,
        output wb_adr, wb_dat_o, wb_cyc, wb_stb, wb_we, wb_sel,
        input  wb_dat_i, wb_ack, wb_err, wb_rty
    );

    modport slave (
        output cmd_valid, cmd_tx, cmd_len, cmd_div, cmd_ss, cmd_flags,
        input  cmd_ready,
        input  rsp_valid, rsp_rx, rsp_err,
        output rsp_ready,
        input  wb_adr, wb_dat_o, wb_cyc, wb_stb, wb_we, wb_sel,
        output wb_dat_i, wb_ack, wb_err, wb_rty
    );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - Wishbone master sequencing one SPI core transfer (optional SPI_IRQ_WAIT_EN)
module spi_xfer_sequencer #(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    spi_xfer_sequencer_if.master bus
`ifdef SPI_IRQ_WAIT_EN
    ,
    input  logic spi_int
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_DIV, S_WR_SS, S_WR_TX, S_WR_CTRL, S_WR_GO,
        S_WAIT_IRQ, S_POLL, S_RD_RX, S_CLR_SS, S_DONE
    } state_t;

    // last stall cycle before the access is abandoned
    localparam logic [7:0] LP_TO_LAST = 8'(ACK_TIMEOUT - 1);
`ifdef SPI_IRQ_WAIT_EN
    localparam logic LP_IE = 1'b1;
`else
    localparam logic LP_IE = 1'b0;
`endif

    state_t              r_state, w_nxt_state;
    logic                r_cyc, w_nxt_cyc;
    logic                r_we, w_nxt_we;
    logic [AWIDTH-1:0]   r_adr, w_nxt_adr;
    logic [DWIDTH-1:0]   r_dat_o, w_nxt_dat_o;
    logic [3:0]          r_sel, w_nxt_sel;
    logic [7:0]          r_cnt, w_nxt_cnt;
    logic [31:0]         r_tx, w_nxt_tx;
    logic [6:0]          r_len, w_nxt_len;
    logic [15:0]         r_div, w_nxt_div;
    logic [7:0]          r_ss, w_nxt_ss;
    logic [2:0]          r_flags, w_nxt_flags;
    logic                r_rsp_valid, w_nxt_rsp_valid;
    logic [31:0]         r_rsp_rx, w_nxt_rsp_rx;
    logic                r_rsp_err, w_nxt_rsp_err;

    // access descriptor of the current state
    logic                w_acc_we;
    logic [7:0]          w_acc_adr;
    logic [DWIDTH-1:0]   w_acc_dat;
    state_t              w_succ;
    logic [31:0]         w_ctrl;
    logic                w_drop;

    // decode which register access the current state performs and where success leads
    always_comb begin
        w_ctrl    = {18'h0, 1'b0, LP_IE, r_flags, 1'b0, 1'b0, r_len};
        w_acc_we  = 1'b0;
        w_acc_adr = 8'h00;
        w_acc_dat = '0;
        w_succ    = r_state;
        case (r_state)
            S_WR_DIV:  begin w_acc_we = 1'b1; w_acc_adr = 8'h14; w_acc_dat = DWIDTH'(r_div);  w_succ = S_WR_SS;   end
            S_WR_SS:   begin w_acc_we = 1'b1; w_acc_adr = 8'h18; w_acc_dat = DWIDTH'(r_ss);   w_succ = S_WR_TX;   end
            S_WR_TX:   begin w_acc_we = 1'b1; w_acc_adr = 8'h00; w_acc_dat = DWIDTH'(r_tx);   w_succ = S_WR_CTRL; end
            S_WR_CTRL: begin w_acc_we = 1'b1; w_acc_adr = 8'h10; w_acc_dat = DWIDTH'(w_ctrl); w_succ = S_WR_GO;   end
            S_WR_GO: begin
                w_acc_we  = 1'b1;
                w_acc_adr = 8'h10;
                w_acc_dat = DWIDTH'(w_ctrl | 32'h0000_0100);
`ifdef SPI_IRQ_WAIT_EN
                w_succ    = S_WAIT_IRQ;
`else
                w_succ    = S_POLL;
`endif
            end
            S_POLL: begin
                w_acc_adr = 8'h10;
`ifdef SPI_IRQ_WAIT_EN
                // the interrupt already signalled completion; this read only clears it
                w_succ    = S_RD_RX;
`else
                w_succ    = bus.wb_dat_i[8] ? S_POLL : S_RD_RX;
`endif
            end
            S_RD_RX:   begin w_acc_adr = 8'h00; w_succ = S_CLR_SS; end
            S_CLR_SS:  begin w_acc_we = 1'b1; w_acc_adr = 8'h18; w_succ = S_DONE; end
            default:   begin w_succ = r_state; end
        endcase
    end

    // next-state and output logic: idle phase, active phase, termination handling
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cyc       = r_cyc;
        w_nxt_we        = r_we;
        w_nxt_adr       = r_adr;
        w_nxt_dat_o     = r_dat_o;
        w_nxt_sel       = r_sel;
        w_nxt_cnt       = r_cnt;
        w_nxt_tx        = r_tx;
        w_nxt_len       = r_len;
        w_nxt_div       = r_div;
        w_nxt_ss        = r_ss;
        w_nxt_flags     = r_flags;
        w_nxt_rsp_valid = r_rsp_valid;
        w_nxt_rsp_rx    = r_rsp_rx;
        w_nxt_rsp_err   = r_rsp_err;
        w_drop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_nxt_tx      = bus.cmd_tx;
                    w_nxt_len     = bus.cmd_len;
                    w_nxt_div     = bus.cmd_div;
                    w_nxt_ss      = bus.cmd_ss;
                    w_nxt_flags   = bus.cmd_flags;
                    w_nxt_rsp_rx  = 32'h0;
                    w_nxt_rsp_err = 1'b0;
                    w_nxt_state   = S_WR_DIV;
                end
            end
            S_WAIT_IRQ: begin
`ifdef SPI_IRQ_WAIT_EN
                if (spi_int) begin
                    w_nxt_state = S_POLL;
                end
`endif
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    w_nxt_rsp_valid = 1'b0;
                    w_nxt_state     = S_IDLE;
                end
            end
            default: begin
                if (!r_cyc) begin
                    // idle phase: launch the access with every bus field at once
                    w_nxt_cyc   = 1'b1;
                    w_nxt_we    = w_acc_we;
                    w_nxt_adr   = AWIDTH'(w_acc_adr);
                    w_nxt_dat_o = w_acc_dat;
                    w_nxt_sel   = 4'hF;
                    w_nxt_cnt   = 8'h00;
                end else if (bus.wb_ack) begin
                    w_drop      = 1'b1;
                    w_nxt_state = w_succ;
                    if (r_state == S_RD_RX) begin
                        w_nxt_rsp_rx = 32'(bus.wb_dat_i);
                    end
                    if (w_succ == S_DONE) begin
                        w_nxt_rsp_valid = 1'b1;
                    end
                end else if (bus.wb_err || (!bus.wb_rty && r_cnt == LP_TO_LAST)) begin
                    // abandon the rest of the sequence; SS stays as programmed
                    w_drop          = 1'b1;
                    w_nxt_rsp_err   = 1'b1;
                    w_nxt_rsp_rx    = 32'h0;
                    w_nxt_rsp_valid = 1'b1;
                    w_nxt_state     = S_DONE;
                end else if (bus.wb_rty) begin
                    // same state re-launches the identical access after the idle cycle
                    w_drop    = 1'b1;
                    w_nxt_cnt = 8'h00;
                end else begin
                    w_nxt_cnt = r_cnt + 8'h01;
                end
            end
        endcase
        if (w_drop) begin
            w_nxt_cyc   = 1'b0;
            w_nxt_we    = 1'b0;
            w_nxt_adr   = '0;
            w_nxt_dat_o = '0;
            w_nxt_sel   = 4'h0;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat_o     <= '0;
            r_sel       <= 4'h0;
            r_cnt       <= 8'h00;
            r_tx        <= 32'h0;
            r_len       <= 7'h0;
            r_div       <= 16'h0;
            r_ss        <= 8'h0;
            r_flags     <= 3'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_rx    <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cyc       <= w_nxt_cyc;
            r_we        <= w_nxt_we;
            r_adr       <= w_nxt_adr;
            r_dat_o     <= w_nxt_dat_o;
            r_sel       <= w_nxt_sel;
            r_cnt       <= w_nxt_cnt;
            r_tx        <= w_nxt_tx;
            r_len       <= w_nxt_len;
            r_div       <= w_nxt_div;
            r_ss        <= w_nxt_ss;
            r_flags     <= w_nxt_flags;
            r_rsp_valid <= w_nxt_rsp_valid;
            r_rsp_rx    <= w_nxt_rsp_rx;
            r_rsp_err   <= w_nxt_rsp_err;
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rx    = r_rsp_rx;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.wb_cyc    = r_cyc;
    assign bus.wb_stb    = r_cyc;
    assign bus.wb_we     = r_we;
    assign bus.wb_adr    = r_adr;
    assign bus.wb_dat_o  = r_dat_o;
    assign bus.wb_sel    = r_sel;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - directed self-checking bench for spi_xfer_sequencer with a Wishbone slave model
module tb_spi_xfer_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_xfer_sequencer_if ifc ();

`ifdef SPI_IRQ_WAIT_EN
    logic spi_int = 1'b1;
    spi_xfer_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(ifc), .spi_int(spi_int));
`else
    spi_xfer_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
`endif

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // slave model controls (bench-written)
    int   busy_target = 0;
    int   poll_base = 0;
    logic rty_arm = 1'b0;
    int   rty_base = 0;
    logic stall_ss = 1'b0;
    logic err_ctrl = 1'b0;

    // slave model state (written only by the slave process)
    logic [40:0] log_ent [0:63];
    int   n_log = 0;
    int   n_polls = 0;
    int   n_rty = 0;
    logic [40:0] rty_ent = '0;
    int   stall_cnt = 0;
    int   b2b_viol = 0;
    logic prev_term = 1'b0;

    logic       w_req, w_go, w_stall, w_rty, w_err;
    logic [7:0] w_a;
    assign w_a     = ifc.wb_adr[7:0];
    assign w_req   = ifc.wb_cyc && ifc.wb_stb;
    assign w_go    = (n_polls - poll_base) < busy_target;
    assign w_stall = stall_ss && w_a == 8'h18;
    assign w_rty   = rty_arm && (n_rty == rty_base) && w_a == 8'h00 && ifc.wb_we;
    assign w_err   = err_ctrl && w_a == 8'h10 && ifc.wb_we && !ifc.wb_dat_o[8];
    assign ifc.wb_ack   = w_req && !w_stall && !w_rty && !w_err;
    assign ifc.wb_rty   = w_req && w_rty;
    assign ifc.wb_err   = w_req && w_err;
    assign ifc.wb_dat_i = (w_a == 8'h10) ? (w_go ? 32'h100 : 32'h0) :
                          (w_a == 8'h00) ? 32'h5A : 32'h0;

    always @(posedge clk) begin
        if (w_req && ifc.wb_ack && n_log < 64) begin
            log_ent[n_log] <= {ifc.wb_we, w_a, ifc.wb_we ? ifc.wb_dat_o : ifc.wb_dat_i};
            n_log <= n_log + 1;
            if (!ifc.wb_we && w_a == 8'h10 && w_go) n_polls <= n_polls + 1;
        end
        if (ifc.wb_rty) begin
            n_rty   <= n_rty + 1;
            rty_ent <= {ifc.wb_we, w_a, ifc.wb_dat_o};
        end
        if (w_req && !ifc.wb_ack && !ifc.wb_rty && !ifc.wb_err) stall_cnt <= stall_cnt + 1;
        if (w_req && prev_term) b2b_viol <= b2b_viol + 1;
        prev_term <= w_req && (ifc.wb_ack || ifc.wb_err || ifc.wb_rty);
    end

    function automatic logic [40:0] exp_std(input int i);
        case (i)
            0: exp_std = {1'b1, 8'h14, 32'h0000_0004};
            1: exp_std = {1'b1, 8'h18, 32'h0000_0001};
            2: exp_std = {1'b1, 8'h00, 32'hA5A5_1234};
            3: exp_std = {1'b1, 8'h10, 32'h0000_0008};
            4: exp_std = {1'b1, 8'h10, 32'h0000_0108};
            5: exp_std = {1'b0, 8'h10, 32'h0000_0000};
            6: exp_std = {1'b0, 8'h00, 32'h0000_005A};
            default: exp_std = {1'b1, 8'h18, 32'h0000_0000};
        endcase
    endfunction

    int log_base = 0;
    int stall_base = 0;

    task automatic mark();
        log_base   = n_log;
        stall_base = stall_cnt;
        poll_base  = n_polls;
        rty_base   = n_rty;
    endtask

    task automatic check_std_log(input string tag);
        check_eq({tag, "_nacc"}, 64'(n_log - log_base), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (log_base + i < 64)
                check_eq($sformatf("%s_acc%0d", tag, i), 64'(log_ent[log_base + i]), 64'(exp_std(i)));
        end
    endtask

    task automatic do_cmd(output int cycles);
        @(negedge clk);
        ifc.cmd_tx    = 32'hA5A5_1234;
        ifc.cmd_len   = 7'd8;
        ifc.cmd_div   = 16'h0004;
        ifc.cmd_ss    = 8'h01;
        ifc.cmd_flags = 3'b000;
        ifc.cmd_valid = 1'b1;
        @(posedge clk);
        #1 ifc.cmd_valid = 1'b0;
        cycles = 0;
        while (!ifc.rsp_valid && cycles < 2000) begin
            @(posedge clk);
            #1 cycles++;
        end
    endtask

    task automatic finish_rsp(input string tag, input int hold);
        int bad;
        logic [31:0] rx0;
        logic err0;
        bad  = 0;
        rx0  = ifc.rsp_rx;
        err0 = ifc.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1 if (!ifc.rsp_valid || ifc.rsp_rx !== rx0 || ifc.rsp_err !== err0 || ifc.cmd_ready) bad++;
        end
        if (hold > 0) check_eq({tag, "_hold_stable_bad"}, 64'(bad), 64'd0);
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        #1 ifc.rsp_ready = 1'b0;
        check_eq({tag, "_rsp_valid_after_hs"}, 64'(ifc.rsp_valid), 64'd0);
        check_eq({tag, "_cmd_ready_after_hs"}, 64'(ifc.cmd_ready), 64'd1);
    endtask

    initial begin
        int cyc;
        int polls;
        int found;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_tx    = '0;
        ifc.cmd_len   = '0;
        ifc.cmd_div   = '0;
        ifc.cmd_ss    = '0;
        ifc.cmd_flags = '0;
        ifc.rsp_ready = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cyc", 64'(ifc.wb_cyc), 64'd0);
        check_eq("rst_stb", 64'(ifc.wb_stb), 64'd0);
        check_eq("rst_we", 64'(ifc.wb_we), 64'd0);
        check_eq("rst_adr", 64'(ifc.wb_adr), 64'd0);
        check_eq("rst_dat_o", 64'(ifc.wb_dat_o), 64'd0);
        check_eq("rst_sel", 64'(ifc.wb_sel), 64'd0);
        check_eq("rst_rsp", 64'({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rx}), 64'd0);
        check_eq("rst_cmd_ready", 64'(ifc.cmd_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;

        // basic transfer, GO clears on first poll
        mark();
        busy_target = 0;
        do_cmd(cyc);
        check_eq("t1_cycles", 64'(cyc), 64'd16);
        check_eq("t1_rx", 64'(ifc.rsp_rx), 64'h5A);
        check_eq("t1_err", 64'(ifc.rsp_err), 64'd0);
        check_eq("t1_sel", 64'(ifc.wb_sel), 64'd0);
        check_std_log("t1");
        finish_rsp("t1", 10);

        // GO stays set for 3 polls
        mark();
        busy_target = 3;
        do_cmd(cyc);
        polls = 0;
        for (int i = log_base; i < n_log && i < 64; i++)
            if (log_ent[i][40:32] == {1'b0, 8'h10}) polls++;
        check_eq("t2_cycles", 64'(cyc), 64'd22);
        check_eq("t2_polls", 64'(polls), 64'd4);
        check_eq("t2_nacc", 64'(n_log - log_base), 64'd11);
        check_eq("t2_rx", 64'(ifc.rsp_rx), 64'h5A);
        finish_rsp("t2", 0);
        busy_target = 0;

        // one rty on WR_TX
        mark();
        rty_arm = 1'b1;
        do_cmd(cyc);
        rty_arm = 1'b0;
        check_eq("t3_cycles", 64'(cyc), 64'd18);
        check_eq("t3_nrty", 64'(n_rty - rty_base), 64'd1);
        check_eq("t3_rty_access", 64'(rty_ent), 64'({1'b1, 8'h00, 32'hA5A5_1234}));
        check_eq("t3_rx", 64'(ifc.rsp_rx), 64'h5A);
        check_eq("t3_err", 64'(ifc.rsp_err), 64'd0);
        check_std_log("t3");
        finish_rsp("t3", 0);

        // WR_SS never acked
        mark();
        stall_ss = 1'b1;
        do_cmd(cyc);
        check_eq("t4_cycles", 64'(cyc), 64'd258);
        check_eq("t4_stalls", 64'(stall_cnt - stall_base), 64'd255);
        check_eq("t4_err", 64'(ifc.rsp_err), 64'd1);
        check_eq("t4_rx", 64'(ifc.rsp_rx), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("t4_cyc_quiet", 64'(ifc.wb_cyc), 64'd0);
        check_eq("t4_nacc", 64'(n_log - log_base), 64'd1);
        stall_ss = 1'b0;
        finish_rsp("t4", 0);

        // err on first CTRL write
        mark();
        err_ctrl = 1'b1;
        do_cmd(cyc);
        err_ctrl = 1'b0;
        check_eq("t5_cycles", 64'(cyc), 64'd8);
        check_eq("t5_err", 64'(ifc.rsp_err), 64'd1);
        check_eq("t5_nacc", 64'(n_log - log_base), 64'd3);
        finish_rsp("t5", 0);

        // reset during POLL with stb high
        mark();
        busy_target = 1000;
        @(negedge clk);
        ifc.cmd_valid = 1'b1;
        @(posedge clk);
        #1 ifc.cmd_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(posedge clk);
            #1 if (ifc.wb_stb && !ifc.wb_we && ifc.wb_adr[7:0] == 8'h10) found = 1;
        end
        check_eq("t6_reached_poll", 64'(found), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_cyc_stb", 64'({ifc.wb_cyc, ifc.wb_stb}), 64'd0);
        check_eq("t6_rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        busy_target = 0;
        mark();
        do_cmd(cyc);
        check_eq("t6_cycles", 64'(cyc), 64'd16);
        check_std_log("t6");
        finish_rsp("t6", 0);

        check_eq("idle_between_cycles_viol", 64'(b2b_viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_xfer_sequencer.md
Name: spi_xfer_sequencer

Overview:
Synthesizable Wishbone master that sequences one complete SPI transfer on the SPI core's register port: program, start, poll, read back, deselect. It accepts one command over a valid/ready interface and returns received data over a valid/ready interface. Sits between system logic and the SPI core slave port; replaces bench-driven register programming in the integrated design.

Parameters:
AWIDTH, 32, Wishbone address width
DWIDTH, 32, Wishbone data width (fixed 32 in this core)
ACK_TIMEOUT, 255, max cycles stb may wait for ack/err/rty before abort (8-bit counter)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_tx  in  32  transmit word
cmd_len  in  7  CTRL CHAR_LEN (0 = 128 bits)
cmd_div  in  16  DIVIDER value
cmd_ss  in  8  slave-select mask
cmd_flags  in  3  {LSB, TX_NEG, RX_NEG} -> CTRL[11], [10], [9]
rsp_valid  out  1  response present
rsp_ready  in  1  response accepted
rsp_rx  out  32  received word
rsp_err  out  1  transfer aborted
wb_adr  out  AWIDTH  address
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_cyc, wb_stb  out  1  cycle/strobe
wb_we  out  1  write enable
wb_sel  out  4  byte selects, always 4'hF during cycles
wb_ack, wb_err, wb_rty  in  1  slave termination

Behaviour:
- Reset (async, rst_n low): state IDLE; cyc, stb, we = 0; adr, dat_o, sel = 0; rsp_valid = 0; rsp_rx = 0; rsp_err = 0; timeout counter = 0. Reset mid-cycle drops cyc/stb immediately; no completion.
- Command capture: cmd_valid && cmd_ready at posedge latches all cmd_* fields; cmd_ready low until return to IDLE.
- Bus cycle: assert cyc, stb, we, adr, dat_o, sel together on the cycle after entering a bus state; hold stable until ack/err/rty sampled high; deassert next cycle; minimum one idle cycle (cyc=0) between bus cycles.
- rty: reissue same access after idle cycle; timeout counter reset.
- err, or counter reaching ACK_TIMEOUT: drop cyc/stb, set rsp_err=1, rsp_rx=0, go DONE (remaining steps skipped, SS left as programmed).
- States and accesses, in order:
  IDLE -> WR_DIV: write 0x14 <= {16'h0, div}
  WR_SS: write 0x18 <= {24'h0, ss}
  WR_TX: write 0x00 <= tx
  WR_CTRL: write 0x10 <= {18'h0, ASS=0, IE, flags, GO=0, 0, len}
  WR_GO: same word with bit 8 (GO) = 1
  POLL: read 0x10; if dat_i[8]=1 repeat POLL after idle cycle, else RD_RX
  RD_RX: read 0x00, latch rsp_rx
  CLR_SS: write 0x18 <= 0
  DONE: rsp_valid=1; rsp_rx/rsp_err stable; on rsp_valid && rsp_ready -> IDLE, rsp_valid=0 next cycle.
- IE bit (CTRL[12]) = 0 unless optional feature enabled.
- Zero-wait slave: each access = 2 cycles (active + idle); full successful transfer with one poll = 16 cycles from accept to rsp_valid, plus 2 per extra poll.
- Poll loop has no iteration limit; only per-access timeout applies.

Optional Feature:
SPI_IRQ_WAIT_EN: adds input spi_int (core interrupt, active-high). CTRL writes set IE=1; after WR_GO enter WAIT_IRQ (no bus activity) until spi_int=1, then a single POLL read (clears interrupt) -> RD_RX regardless of GO bit. Without macro: no spi_int port, IE=0, pure polling as above.

Test Plan:
- Zero-wait slave model, cmd tx=32'hA5A5_1234, len=8, div=16'h0004, ss=8'h01, flags=0, GO clears on first poll -> writes 0x14<=4, 0x18<=1, 0x00<=A5A51234, 0x10<=0x008, 0x10<=0x108; reads 0x10, 0x00; write 0x18<=0; rsp_valid at cycle 16, rsp_rx = slave RX value 32'h0000_005A, rsp_err=0.
- GO stays set for 3 polls -> exactly 4 reads of 0x10, each separated by an idle cycle; rsp_valid at cycle 22.
- Slave asserts rty once on WR_TX -> same write reissued with identical adr/data; final result identical to first scenario.
- Slave never acks WR_SS -> cyc drops after 255 stall cycles, rsp_valid=1, rsp_err=1, rsp_rx=0; no further bus cycles.
- rsp_ready held low 10 cycles in DONE -> rsp_valid, rsp_rx stable, cmd_ready=0; cmd_ready=1 cycle after handshake.
- rst_n pulsed low during POLL with stb high -> cyc/stb/rsp_valid 0 immediately; next command runs full sequence from WR_DIV.
